// File: rtl/mult_pkg.sv
// Shared constants and golden product function for the array multiplier.
package mult_pkg;

  localparam int MULT_WIDTH_DEFAULT = 2;
  localparam int MULT_WIDTH_MAX     = 8;

  function automatic logic [2*MULT_WIDTH_MAX-1:0] mult_ref(
    input logic [MULT_WIDTH_MAX-1:0] a,
    input logic [MULT_WIDTH_MAX-1:0] b
  );
    return (2*MULT_WIDTH_MAX)'(a) * (2*MULT_WIDTH_MAX)'(b);
  endfunction

endpackage

// File: rtl/mult_cla_adder.sv
// N-bit carry-lookahead adder; purely combinational, no flow control.
module mult_cla_adder
  import mult_pkg::*;
#(
  parameter int N = MULT_WIDTH_DEFAULT
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;
  logic         term;

  assign g = x & y;
  assign p = x ^ y;

  // Each carry is a flat sum of generate terms propagated to it, so no carry waits on another.
  always_comb begin
    c    = '0;
    term = 1'b0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      term = cin;
      for (int k = 0; k <= i; k++) term = term & p[k];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) term = term & p[k];
        c[i+1] = c[i+1] | term;
      end
    end
  end

  assign sum  = p ^ c[N-1:0];
  assign cout = c[N];

endmodule

// File: rtl/mult_array_reg.sv
// Unsigned WIDTH x WIDTH array multiplier, registered product; latency 1 (2 with MULT_INPUT_REG_EN).
// Accepts one operand pair per cycle, never stalls; s holds while in_valid is low.
module mult_array_reg
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               in_valid,
  output logic [2*WIDTH-1:0] s,
  output logic               out_valid
);

  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               op_vld;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] s_d, s_q;
  logic               out_vld_d, out_vld_q;

`ifdef MULT_INPUT_REG_EN
  logic [WIDTH-1:0] a_q, b_q;
  logic             in_vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      in_vld_q <= 1'b0;
    end else begin
      a_q      <= a;
      b_q      <= b;
      in_vld_q <= in_valid;
    end
  end

  assign op_a   = a_q;
  assign op_b   = b_q;
  assign op_vld = in_vld_q;
`else
  assign op_a   = a;
  assign op_b   = b;
  assign op_vld = in_valid;
`endif

  // Row i adds partial product i to the upper WIDTH bits of row i-1; the dropped LSB is final.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_row
    logic [WIDTH-1:0] pp;
    logic [WIDTH:0]   acc;

    assign pp = op_a & {WIDTH{op_b[gi]}};

    if (gi == 0) begin : g_first
      assign acc = {1'b0, pp};
    end else begin : g_add
      mult_cla_adder #(.N(WIDTH)) u_row (
        .x    (g_row[gi-1].acc[WIDTH:1]),
        .y    (pp),
        .cin  (1'b0),
        .sum  (acc[WIDTH-1:0]),
        .cout (acc[WIDTH])
      );
    end

    if (gi < WIDTH - 1) begin : g_lsb
      assign prod[gi] = acc[0];
    end
  end

  assign prod[2*WIDTH-1:WIDTH-1] = g_row[WIDTH-1].acc;

  always_comb begin
    s_d       = s_q;
    out_vld_d = 1'b0;
    if (op_vld) begin
      s_d       = prod;
      out_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q       <= '0;
      out_vld_q <= 1'b0;
    end else begin
      s_q       <= s_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign s         = s_q;
  assign out_valid = out_vld_q;

endmodule

// File: tb/tb_mult_array_reg.sv
// Bench for mult_array_reg: a W=2 and a W=4 instance driven side by side against a queue-based model.
module tb_mult_array_reg;
  import mult_pkg::*;

`ifdef MULT_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] a2 = '0, b2 = '0;
  logic       v2 = 1'b0;
  logic [3:0] s2;
  logic       o2;
  logic [3:0] a4 = '0, b4 = '0;
  logic       v4 = 1'b0;
  logic [7:0] s4;
  logic       o4;

  always #5 clk = ~clk;

  mult_array_reg u_dut2 (
    .clk(clk), .rst(rst), .a(a2), .b(b2), .in_valid(v2), .s(s2), .out_valid(o2)
  );

  mult_array_reg #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(v4), .s(s4), .out_valid(o4)
  );

  typedef struct {
    bit v;
    int p;
  } stage_t;

  typedef struct {
    int a;
    int b;
    int p;
  } vec_t;

  stage_t q2[$];
  stage_t q4[$];
  int     ms2 = 0, ms4 = 0;
  bit     mv2 = 1'b0, mv4 = 1'b0;
  int     n_chk = 0;
  int     n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q2.delete();
    q4.delete();
    for (int i = 0; i < LAT - 1; i++) begin
      q2.push_back('{1'b0, 0});
      q4.push_back('{1'b0, 0});
    end
    ms2 = 0; ms4 = 0;
    mv2 = 1'b0; mv4 = 1'b0;
  endfunction

  // One clock: drive on the falling edge, advance the model at the rising edge, compare 1 time unit later.
  task automatic step(input int xa2, input int xb2, input bit xv2,
                      input int xa4, input int xb4, input bit xv4, input bit xr);
    stage_t h;
    @(negedge clk);
    a2 = xa2[1:0]; b2 = xb2[1:0]; v2 = xv2;
    a4 = xa4[3:0]; b4 = xb4[3:0]; v4 = xv4;
    rst = xr;
    @(posedge clk);
    if (xr) begin
      model_reset();
    end else begin
      q2.push_back('{xv2, xa2 * xb2});
      h = q2.pop_front();
      mv2 = h.v;
      if (h.v) ms2 = h.p;
      q4.push_back('{xv4, int'(mult_ref(8'(xa4), 8'(xb4))) });
      h = q4.pop_front();
      mv4 = h.v;
      if (h.v) ms4 = h.p;
    end
    #1;
    check("model_s2", int'(s2), ms2);
    check("model_out_valid2", int'(o2), int'(mv2));
    check("model_s4", int'(s4), ms4);
    check("model_out_valid4", int'(o4), int'(mv4));
  endtask

  task automatic idle();
    step(0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  vec_t tbl[16];
  int   exp16[16] = '{0, 0, 0, 0, 0, 1, 2, 3, 0, 2, 4, 6, 0, 3, 6, 9};

  initial begin
    int idx;
    int first;
    int width;

    for (int i = 0; i < 16; i++) begin
      tbl[i].a = i / 4;
      tbl[i].b = i % 4;
      tbl[i].p = exp16[i];
    end
    model_reset();

    // Reset state
    step(0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
    step(0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
    check("reset_s", int'(s2), 0);
    check("reset_out_valid", int'(o2), 0);

    // Exhaustive W=2 sweep, valid every cycle
    for (int k = 0; k < 16 + LAT - 1; k++) begin
      if (k < 16) step(tbl[k].a, tbl[k].b, 1'b1, 0, 0, 1'b0, 1'b0);
      else        idle();
      idx = k - LAT + 1;
      if (idx >= 0 && idx < 16) begin
        check($sformatf("sweep_s_%0dx%0d", tbl[idx].a, tbl[idx].b), int'(s2), tbl[idx].p);
        check("sweep_out_valid", int'(o2), 1);
      end
    end

    // rst wins over in_valid, then product appears after release
    step(3, 3, 1'b1, 0, 0, 1'b0, 1'b1);
    check("rst_hold_s", int'(s2), 0);
    check("rst_hold_out_valid", int'(o2), 0);
    step(3, 3, 1'b1, 0, 0, 1'b0, 1'b0);
    repeat (LAT - 1) step(3, 3, 1'b1, 0, 0, 1'b0, 1'b0);
    check("rst_release_s", int'(s2), 9);
    check("rst_release_out_valid", int'(o2), 1);

    // Gap: s holds while in_valid is low even as a/b toggle
    step(3, 2, 1'b1, 0, 0, 1'b0, 1'b0);
    repeat (LAT - 1) idle();
    check("gap_s", int'(s2), 6);
    check("gap_out_valid", int'(o2), 1);
    for (int i = 0; i < 3; i++) begin
      step(i + 1, 3 - i, 1'b0, i * 5, 15 - i, 1'b0, 1'b0);
      check("gap_idle_s", int'(s2), 6);
      check("gap_idle_out_valid", int'(o2), 0);
    end

    // Reset mid-stream discards the in-flight product
    step(2, 2, 1'b1, 0, 0, 1'b0, 1'b0);
    step(0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
    check("midrst_s", int'(s2), 0);
    check("midrst_out_valid", int'(o2), 0);
    for (int i = 0; i < LAT + 1; i++) begin
      idle();
      check("midrst_idle_s", int'(s2), 0);
      check("midrst_idle_out_valid", int'(o2), 0);
    end

    // Single pulse: latency and width of out_valid
    first = -1;
    width = 0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 1) step(1, 3, 1'b1, 0, 0, 1'b0, 1'b0);
      else        idle();
      if (o2) begin
        if (first < 0) first = c;
        width++;
      end
    end
    check("pulse_latency", first, LAT);
    check("pulse_width", width, 1);
    check("pulse_s", int'(s2), 3);

    // W=4: maximum operands, then random stream with rare resets
    step(0, 0, 1'b0, 15, 15, 1'b1, 1'b0);
    repeat (LAT - 1) idle();
    check("w4_max_s", int'(s4), 225);
    check("w4_max_out_valid", int'(o4), 1);
    for (int i = 0; i < 1000; i++) begin
      step(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 99) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
